// File: rtl/xphy_link_monitor_pkg.sv
// Shared types and helpers for the 10GBASE-R link supervisor.
// Holds the per-port FSM encoding and the XGMII start-of-frame decode.
package xphy_link_monitor_pkg;

    typedef enum logic [1:0] {
        ST_DOWN      = 2'd0,
        ST_UP_PEND   = 2'd1,
        ST_UP        = 2'd2,
        ST_DOWN_PEND = 2'd3
    } link_state_e;

    localparam logic [7:0] XGMII_START = 8'hFB;

    // A frame can only start on lane 0 or lane 4 of a 64-bit XGMII word.
    function automatic logic sof_detect(
        input logic [7:0] rxd_l0,
        input logic       rxc_l0,
        input logic [7:0] rxd_l4,
        input logic       rxc_l4
    );
        return (rxc_l0 && (rxd_l0 == XGMII_START)) ||
               (rxc_l4 && (rxd_l4 == XGMII_START));
    endfunction

endpackage

// File: rtl/xphy_link_monitor_if.sv
// Bundle of the per-port PHY/XGMII inputs and the link/LED/flap outputs.
// The master drives status and receive data; the monitor is the slave.
interface xphy_link_monitor_if #(
    parameter int NPORTS = 4,
    parameter int FLAP_W = 16
);
    logic [8*NPORTS-1:0]      xphy_status;
    logic [64*NPORTS-1:0]     xgmii_rxd;
    logic [8*NPORTS-1:0]      xgmii_rxc;
    logic                     clr_flaps;
    logic [NPORTS-1:0]        link_up;
    logic [NPORTS-1:0]        led;
    logic [FLAP_W*NPORTS-1:0] flap_count;

    modport master (
        output xphy_status, xgmii_rxd, xgmii_rxc, clr_flaps,
        input  link_up, led, flap_count
    );

    modport slave (
        input  xphy_status, xgmii_rxd, xgmii_rxc, clr_flaps,
        output link_up, led, flap_count
    );
endinterface

// File: rtl/xphy_link_monitor_ch.sv
// One port of the link supervisor: block-lock debounce FSM, flap counter
// and the activity-blink timer that drives the port LED.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_DOWN      | link down, waiting for block lock
// ST_UP_PEND   | lock seen, counting stable-high cycles before declaring up
// ST_UP        | link qualified up
// ST_DOWN_PEND | lock lost, counting stable-low cycles before declaring down
module xphy_link_monitor_ch
    import xphy_link_monitor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 156250,
    parameter int ACT_CYCLES      = 7812500,
    parameter int FLAP_W          = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              i_lock,
    input  logic              i_sof,
    input  logic              i_clr_flaps,
    output logic              o_link_up,
    output logic              o_led,
    output logic [FLAP_W-1:0] o_flap_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(2*ACT_CYCLES + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] ACNT_LOAD = AW'(2*ACT_CYCLES);
    localparam logic [AW-1:0] ACNT_HALF = AW'(ACT_CYCLES);

    link_state_e       r_state, w_state_nxt;
    logic [DW-1:0]     r_dcnt, w_dcnt_nxt;
    logic [AW-1:0]     r_acnt;
    logic [FLAP_W-1:0] r_flap_count;
    logic              r_flap_inc;
    logic              r_link_up;
    logic              r_led;
    logic              w_flap_evt;
    logic              w_up;
    logic              w_up_nxt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_DOWN;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_flap_evt  = 1'b0;
        case (r_state)
            ST_DOWN: begin
                if (i_lock) begin
                    w_state_nxt = ST_UP_PEND;
                    w_dcnt_nxt  = '0;
                end
            end
            ST_UP_PEND: begin
                if (!i_lock)                  w_state_nxt = ST_DOWN;
                else if (r_dcnt == DCNT_LAST) w_state_nxt = ST_UP;
                else                          w_dcnt_nxt  = r_dcnt + 1'b1;
            end
            ST_UP: begin
                if (!i_lock) begin
                    w_state_nxt = ST_DOWN_PEND;
                    w_dcnt_nxt  = '0;
                end
            end
            ST_DOWN_PEND: begin
                if (i_lock) begin
                    w_state_nxt = ST_UP;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state_nxt = ST_DOWN;
                    w_flap_evt  = 1'b1;
                end else begin
                    w_dcnt_nxt  = r_dcnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_DOWN;
        endcase
    end

    assign w_up     = (r_state == ST_UP) || (r_state == ST_DOWN_PEND);
    assign w_up_nxt = (w_state_nxt == ST_UP) || (w_state_nxt == ST_DOWN_PEND);

    // The flap increment lands one edge after the FSM reaches DOWN so it lines
    // up with the link_up fall; a clear on either edge cancels it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_link_up    <= 1'b0;
            r_led        <= 1'b0;
            r_flap_inc   <= 1'b0;
            r_flap_count <= '0;
            r_acnt       <= '0;
        end else begin
            r_link_up  <= w_up;
            r_led      <= w_up && (r_acnt <= ACNT_HALF);
            r_flap_inc <= w_flap_evt && !i_clr_flaps;
            if (i_clr_flaps)
                r_flap_count <= '0;
            else if (r_flap_inc && !(&r_flap_count))
                r_flap_count <= r_flap_count + 1'b1;
            if (!w_up_nxt)
                r_acnt <= '0;
            else if (r_acnt != '0)
                r_acnt <= r_acnt - 1'b1;
            else if (i_sof && w_up)
                r_acnt <= ACNT_LOAD;
        end
    end

    assign o_link_up    = r_link_up;
    assign o_led        = r_led;
    assign o_flap_count = r_flap_count;

endmodule

// File: rtl/xphy_link_monitor.sv
// N-port 10GBASE-R link supervisor: slices the packed per-port buses and
// instantiates one debounce/flap/activity channel per port.
module xphy_link_monitor
    import xphy_link_monitor_pkg::*;
#(
    parameter int NPORTS          = 4,
    parameter int DEBOUNCE_CYCLES = 156250,
    parameter int ACT_CYCLES      = 7812500,
    parameter int FLAP_W          = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    xphy_link_monitor_if.slave  bus
);

    logic [NPORTS-1:0]        w_sof;
    logic [NPORTS-1:0]        w_link_up;
    logic [NPORTS-1:0]        w_led;
    logic [FLAP_W*NPORTS-1:0] w_flap_count;
    logic                     w_unused_bits;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        assign w_sof[p] = sof_detect(bus.xgmii_rxd[64*p +: 8],    bus.xgmii_rxc[8*p],
                                     bus.xgmii_rxd[64*p+32 +: 8], bus.xgmii_rxc[8*p+4]);

        xphy_link_monitor_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACT_CYCLES      (ACT_CYCLES),
            .FLAP_W          (FLAP_W)
        ) u_ch (
            .sys_clk      (sys_clk),
            .sys_rst_n    (sys_rst_n),
            .i_lock       (bus.xphy_status[8*p]),
            .i_sof        (w_sof[p]),
            .i_clr_flaps  (bus.clr_flaps),
            .o_link_up    (w_link_up[p]),
            .o_led        (w_led[p]),
            .o_flap_count (w_flap_count[FLAP_W*p +: FLAP_W])
        );
    end

    assign bus.link_up    = w_link_up;
    assign bus.led        = w_led;
    assign bus.flap_count = w_flap_count;

    // Only block-lock and the lane-0/lane-4 start bytes matter here.
    assign w_unused_bits = ^{bus.xphy_status, bus.xgmii_rxd, bus.xgmii_rxc};

endmodule

// File: tb/tb_xphy_link_monitor.sv
// Scoreboard bench for xphy_link_monitor: a per-port behavioural model
// pushes expected outputs each edge, which are popped and compared.
module tb_xphy_link_monitor;
    import xphy_link_monitor_pkg::*;

    localparam int NP  = 4;
    localparam int DEB = 4;
    localparam int ACT = 3;
    localparam int FW  = 4;
    localparam int FMAX = (1 << FW) - 1;

    typedef struct {
        logic [NP-1:0]    lu;
        logic [NP-1:0]    led;
        logic [FW*NP-1:0] fc;
    } exp_t;

    logic sys_clk;
    logic sys_rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];

    bit m_up    [NP];
    int m_run   [NP];
    int m_acnt  [NP];
    int m_fc    [NP];
    bit m_fpend [NP];
    exp_t m_out;

    xphy_link_monitor_if #(.NPORTS(NP), .FLAP_W(FW)) bus ();

    xphy_link_monitor #(
        .NPORTS          (NP),
        .DEBOUNCE_CYCLES (DEB),
        .ACT_CYCLES      (ACT),
        .FLAP_W          (FW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_up[p] = 0; m_run[p] = 0; m_acnt[p] = 0; m_fc[p] = 0; m_fpend[p] = 0;
        end
        m_out.lu = '0; m_out.led = '0; m_out.fc = '0;
    endtask

    // Link toggles after DEB+1 consecutive samples opposite to the current level;
    // outputs reflect the level held before the edge.
    task automatic model_step();
        for (int p = 0; p < NP; p++) begin
            bit lock, sof, was_up;
            logic [7:0]  c;
            logic [63:0] d;
            lock = bus.xphy_status[8*p];
            c = bus.xgmii_rxc[8*p +: 8];
            d = bus.xgmii_rxd[64*p +: 64];
            sof = (c[0] && d[7:0] == 8'hFB) || (c[4] && d[39:32] == 8'hFB);
            m_out.lu[p]  = m_up[p];
            m_out.led[p] = m_up[p] && (m_acnt[p] <= ACT);
            if (bus.clr_flaps) m_fc[p] = 0;
            else if (m_fpend[p] && m_fc[p] < FMAX) m_fc[p]++;
            m_fpend[p] = 0;
            was_up = m_up[p];
            if (lock != m_up[p]) m_run[p]++;
            else m_run[p] = 0;
            if (m_run[p] == DEB + 1) begin
                m_up[p]  = lock;
                m_run[p] = 0;
                if (!lock && !bus.clr_flaps) m_fpend[p] = 1;
            end
            if (!m_up[p]) m_acnt[p] = 0;
            else if (m_acnt[p] > 0) m_acnt[p]--;
            else if (sof && was_up) m_acnt[p] = 2*ACT;
            m_out.fc[FW*p +: FW] = FW'(m_fc[p]);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge sys_clk);
        model_step();
        sb.push_back(m_out);
        #1;
        e = sb.pop_front();
        chk("link_up", 32'(bus.link_up), 32'(e.lu));
        chk("led", 32'(bus.led), 32'(e.led));
        chk("flap_count", 32'(bus.flap_count), 32'(e.fc));
    endtask

    task automatic set_lock(input int p, input bit v);
        bus.xphy_status[8*p] = v;
    endtask

    task automatic sof_on(input int p, input int lane);
        bus.xgmii_rxc[8*p + lane]      = 1'b1;
        bus.xgmii_rxd[64*p + 8*lane +: 8] = XGMII_START;
    endtask

    task automatic sof_off();
        bus.xgmii_rxc = '0;
        bus.xgmii_rxd = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_link_up"}, 32'(bus.link_up), 32'd0);
        chk({tag, "_led"}, 32'(bus.led), 32'd0);
        chk({tag, "_flap"}, 32'(bus.flap_count), 32'd0);
    endtask

    initial begin
        sys_rst_n       = 1'b0;
        bus.xphy_status = '0;
        bus.xgmii_rxd   = '0;
        bus.xgmii_rxc   = '0;
        bus.clr_flaps   = 1'b0;
        model_reset();
        #3;
        chk_all_zero("reset");
        #20;
        sys_rst_n = 1'b1;

        // clean link-up on port 0: rises exactly 5 edges after first high sample
        set_lock(0, 1);
        repeat (5) tick();
        chk("up0_early", 32'(bus.link_up[0]), 32'd0);
        tick();
        chk("up0_latency", 32'(bus.link_up[0]), 32'd1);
        chk("up0_led", 32'(bus.led[0]), 32'd1);
        chk("up0_others", 32'(bus.link_up[3:1]), 32'd0);

        // glitch rejection on port 1
        set_lock(1, 1);
        repeat (6) tick();
        set_lock(1, 0);
        repeat (3) tick();
        set_lock(1, 1);
        repeat (3) tick();
        chk("glitch_link", 32'(bus.link_up[1]), 32'd1);
        chk("glitch_flap", 32'(bus.flap_count[7:4]), 32'd0);
        set_lock(1, 0);
        repeat (6) tick();
        chk("drop_link", 32'(bus.link_up[1]), 32'd0);
        chk("drop_flap", 32'(bus.flap_count[7:4]), 32'd1);

        // activity blink on port 2, lane-4 SOF; second SOF mid-blink ignored
        set_lock(2, 1);
        repeat (6) tick();
        sof_on(2, 4);
        tick();
        sof_off();
        for (int i = 0; i < 6; i++) begin
            if (i == 1) sof_on(2, 4);
            tick();
            if (i == 1) sof_off();
            chk("blink", 32'(bus.led[2]), (i < 3) ? 32'd0 : 32'd1);
        end
        repeat (2) tick();
        set_lock(2, 0);
        repeat (6) tick();
        sof_on(2, 0);
        tick();
        sof_off();
        repeat (3) tick();
        chk("sof_while_down", 32'(bus.led[2]), 32'd0);

        // flap counter saturation on port 3, then clear colliding with a flap
        for (int n = 0; n < 20; n++) begin
            set_lock(3, 1);
            repeat (5) tick();
            set_lock(3, 0);
            repeat (5) tick();
        end
        repeat (2) tick();
        chk("flap_sat", 32'(bus.flap_count[15:12]), 32'd15);
        set_lock(3, 1);
        repeat (5) tick();
        set_lock(3, 0);
        repeat (4) tick();
        bus.clr_flaps = 1'b1;
        tick();
        bus.clr_flaps = 1'b0;
        repeat (2) tick();
        chk("flap_clr", 32'(bus.flap_count[15:12]), 32'd0);
        chk("flap_clr_all", 32'(bus.flap_count), 32'd0);

        // reset mid-qualification on port 3 and mid-blink on port 2
        set_lock(2, 1);
        repeat (6) tick();
        set_lock(3, 1);
        repeat (2) tick();
        sof_on(2, 0);
        tick();
        sof_off();
        tick();
        chk("pre_rst_led", 32'(bus.led[2]), 32'd0);
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(posedge sys_clk);
        #1;
        chk_all_zero("hold_rst");
        #2;
        sys_rst_n = 1'b1;
        repeat (5) tick();
        chk("requal_early", 32'(bus.link_up[3]), 32'd0);
        tick();
        chk("requal_up", 32'(bus.link_up[3]), 32'd1);
        chk("requal_port0", 32'(bus.link_up[0]), 32'd1);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
